// File: rtl/cmp_pkg.sv
// Shared definitions for the sequential compare unit: mode encodings,
// FSM state type and the chunk-count helper.
package cmp_pkg;

    localparam logic [2:0] CMP_SLT  = 3'd0;
    localparam logic [2:0] CMP_SLTU = 3'd1;
    localparam logic [2:0] CMP_SEQ  = 3'd2;
    localparam logic [2:0] CMP_SNE  = 3'd3;
    localparam logic [2:0] CMP_SLE  = 3'd4;
    localparam logic [2:0] CMP_SLEU = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cmp_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/cmp_unit_seq_chunk.sv
// Combinational compare of one CHUNK-bit slice; flip_msb turns the slice
// into offset-binary so the top chunk orders as two's complement.
module cmp_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             flip_msb,
    output logic             lt,
    output logic             eq
);

    logic [CHUNK-1:0] msb_mask;
    logic [CHUNK-1:0] a_adj;
    logic [CHUNK-1:0] b_adj;

    assign msb_mask = {flip_msb, {(CHUNK-1){1'b0}}};
    assign a_adj    = a ^ msb_mask;
    assign b_adj    = b ^ msb_mask;
    assign lt       = (a_adj < b_adj);
    assign eq       = (a == b);

endmodule

// File: rtl/cmp_unit_seq.sv
// Multi-cycle compare unit, MSB chunk first with early exit on the first
// differing chunk. Define CMP_MASK_OUT_EN for an all-ones true result.
module cmp_unit_seq
    import cmp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [2:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam int NCHUNK = cmp_nchunk(WIDTH, CHUNK);
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NCHUNK - 1);

`ifdef CMP_MASK_OUT_EN
    localparam logic [WIDTH-1:0] TRUE_VAL = {WIDTH{1'b1}};
`else
    localparam logic [WIDTH-1:0] TRUE_VAL = WIDTH'(1);
`endif

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             lt_q, lt_d;
    logic             eq_q, eq_d;
    logic [WIDTH-1:0] x_q, y_q;
    logic [2:0]       mode_q;

    logic [CHUNK-1:0] a_c, b_c;
    logic             flip_c, lt_c, eq_c, true_c;

    // Only the top chunk carries the sign bit, so only it gets flipped.
    assign flip_c = ((mode_q == CMP_SLT) || (mode_q == CMP_SLE)) && (idx_q == IDX_TOP);
    assign a_c    = x_q[idx_q*CHUNK +: CHUNK];
    assign b_c    = y_q[idx_q*CHUNK +: CHUNK];

    cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a        (a_c),
        .b        (b_c),
        .flip_msb (flip_c),
        .lt       (lt_c),
        .eq       (eq_c)
    );

    always_ff @(posedge clk) begin
        if (state_q == IDLE && in_valid) begin
            x_q    <= x;
            y_q    <= y;
            mode_q <= mode;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= IDX_TOP;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        lt_d    = lt_q;
        eq_d    = eq_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = RUN;
                    idx_d   = IDX_TOP;
                    lt_d    = 1'b0;
                    eq_d    = 1'b0;
                end
            end
            RUN: begin
                if (!eq_c) begin
                    lt_d    = lt_c;
                    eq_d    = 1'b0;
                    state_d = DONE;
                end else if (idx_q != '0) begin
                    idx_d = idx_q - 1'b1;
                end else begin
                    lt_d    = 1'b0;
                    eq_d    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        true_c = 1'b0;
        case (mode_q)
            CMP_SLT, CMP_SLTU: true_c = lt_q;
            CMP_SEQ:           true_c = eq_q;
            CMP_SNE:           true_c = !eq_q;
            CMP_SLE, CMP_SLEU: true_c = lt_q | eq_q;
            default:           true_c = 1'b0;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign result    = (out_valid && true_c) ? TRUE_VAL : '0;

endmodule

// File: tb/tb_cmp_unit_seq.sv
// Directed bench for cmp_unit_seq (WIDTH=16, CHUNK=4): table of compare
// vectors plus back-pressure and mid-run reset sequences.
module tb_cmp_unit_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x, y;
    logic [2:0]  mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        busy;

    int checks = 0;
    int errors = 0;

`ifdef CMP_MASK_OUT_EN
    localparam logic [15:0] TRUE_V = 16'hFFFF;
`else
    localparam logic [15:0] TRUE_V = 16'h0001;
`endif

    cmp_unit_seq #(.WIDTH(16), .CHUNK(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  m;
        logic [15:0] xv;
        logic [15:0] yv;
        logic        exp_t;
        int          exp_lat;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_req(input logic [2:0] m, input logic [15:0] xv, input logic [15:0] yv,
                           output int lat);
        @(negedge clk);
        mode = m; x = xv; y = yv; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic finish_req(input string name);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk({name, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        logic [15:0] exp_r;

        vecs[0]  = '{3'd0, 16'hFFFF, 16'h0001, 1'b1, 1};
        vecs[1]  = '{3'd1, 16'hFFFF, 16'h0001, 1'b0, 1};
        vecs[2]  = '{3'd2, 16'h1234, 16'h1234, 1'b1, 4};
        vecs[3]  = '{3'd3, 16'h1234, 16'h1234, 1'b0, 4};
        vecs[4]  = '{3'd0, 16'h1230, 16'h1234, 1'b1, 4};
        vecs[5]  = '{3'd4, 16'h8000, 16'h8000, 1'b1, 4};
        vecs[6]  = '{3'd0, 16'h8000, 16'h7FFF, 1'b1, 1};
        vecs[7]  = '{3'd5, 16'h0005, 16'h0003, 1'b0, 4};
        vecs[8]  = '{3'd3, 16'h1234, 16'h1334, 1'b1, 2};
        vecs[9]  = '{3'd6, 16'h0001, 16'h0002, 1'b0, 4};
        vecs[10] = '{3'd4, 16'h7FFF, 16'h8000, 1'b0, 1};
        vecs[11] = '{3'd1, 16'h1200, 16'h1300, 1'b1, 2};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        x = '0; y = '0; mode = '0;
        #12;
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy",      {31'd0, busy},      32'd0);
        chk("rst_result",    {16'd0, result},    32'd0);
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_req(vecs[i].m, vecs[i].xv, vecs[i].yv, lat);
            exp_r = vecs[i].exp_t ? TRUE_V : 16'h0000;
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            chk($sformatf("vec%0d_result", i), {16'd0, result}, {16'd0, exp_r});
            chk($sformatf("vec%0d_in_ready_low", i), {31'd0, in_ready}, 32'd0);
            finish_req($sformatf("vec%0d", i));
        end

        // Back-pressure in DONE with an ignored second request.
        run_req(3'd2, 16'h1234, 16'h1234, lat);
        chk("hold_latency", lat, 4);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; x = 16'hFFFF; y = 16'h0000; mode = 3'd1;
            @(posedge clk);
            #1;
            chk($sformatf("hold%0d_result", i), {16'd0, result}, {16'd0, TRUE_V});
            chk($sformatf("hold%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("hold%0d_in_ready", i), {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk("hold_release_in_ready",  {31'd0, in_ready},  32'd1);
        chk("hold_release_out_valid", {31'd0, out_valid}, 32'd0);
        run_req(3'd1, 16'h0001, 16'h0002, lat);
        chk("after_hold_latency", lat, 4);
        chk("after_hold_result", {16'd0, result}, {16'd0, TRUE_V});
        finish_req("after_hold");

        // Reset while RUN is on chunk index 2.
        @(negedge clk);
        mode = 3'd2; x = 16'h1234; y = 16'h1234; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_in_ready",  {31'd0, in_ready},  32'd1);
        chk("abort_busy",      {31'd0, busy},      32'd0);
        chk("abort_result",    {16'd0, result},    32'd0);
        @(negedge clk) rst = 1'b0;
        run_req(3'd0, 16'h8000, 16'h7FFF, lat);
        chk("after_abort_latency", lat, 1);
        chk("after_abort_result", {16'd0, result}, {16'd0, TRUE_V});
        finish_req("after_abort");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmp_unit_seq.md
Name: cmp_unit_seq

Overview:
- Parametrised multi-cycle compare unit; successor to the fixed 16-bit combinational set-less-than block in the MIPS datapath ALU.
- Compares X and Y CHUNK bits per cycle, MSB chunk first, with early termination on the first differing chunk.
- Supports signed/unsigned ordering and equality modes; valid/ready handshake on input and output.
- Sits beside the ALU in EX, used by slt/sltu/branch-compare paths that tolerate variable latency.

Parameters:
- WIDTH, 16, operand and result width; must be a multiple of CHUNK.
- CHUNK, 4, bits compared per cycle; NCHUNK = WIDTH/CHUNK.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request (high only in IDLE).
- x  input  WIDTH  operand X.
- y  input  WIDTH  operand Y.
- mode  input  3  0=SLT, 1=SLTU, 2=SEQ, 3=SNE, 4=SLE, 5=SLEU, 6/7 reserved.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  compare result (see Optional Feature for true encoding).
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (async, immediate): state=IDLE, in_ready=1, out_valid=0, busy=0, result=0, chunk index=NCHUNK-1, lt/eq flags cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid at a rising edge: capture x, y, mode; set idx=NCHUNK-1; go to RUN. x/y/mode changes after capture are ignored.
- RUN: each edge, compare chunk idx of the captured operands.
  - For signed modes (SLT, SLE), invert the MSB of both operands in the top chunk (offset-binary compare). Unsigned modes compare raw bits.
  - Chunks differ: latch lt, eq=0, go to DONE.
  - Chunks equal and idx>0: idx decrements.
  - Chunks equal and idx==0: eq=1, lt=0, go to DONE.
- Latency: out_valid rises after k edges past acceptance, where k = number of chunks examined (1..NCHUNK).
- DONE: out_valid=1; result held stable until the out_valid && out_ready edge, then go to IDLE. in_ready=0 throughout RUN and DONE; there is no pipelining of requests.
- True condition per mode:
  - SLT/SLTU: lt.
  - SEQ: eq.
  - SNE: !eq.
  - SLE/SLEU: lt|eq.
  - Reserved modes: result false.
- False result is all zeros.
- rst asserted in RUN or DONE aborts the operation; no result is produced.
- out_ready high while not out_valid has no effect.
- in_valid while not in_ready is ignored; the request is not queued.

Optional Feature:
- Macro: CMP_MASK_OUT_EN.
- Defined: a true result drives all WIDTH bits to 1, preserving legacy flag-mask semantics for downstream AND-masking.
- Undefined: a true result drives WIDTH'(1), i.e. MIPS slt semantics (bit 0 only).
- False is all zeros in both cases.

Decomposition:
- Package cmp_pkg holds:
  - mode encodings CMP_SLT..CMP_SLEU;
  - state enum IDLE/RUN/DONE;
  - the function computing NCHUNK.
- One natural combinational sub-module, cmp_chunk:
  - inputs: a, b (CHUNK bits each) and flip_msb;
  - outputs: lt, eq.
  - Instantiated once; the top-level mux selects chunk idx.

Test Plan:
- WIDTH=16, CHUNK=4, SLT, x=0xFFFF, y=0x0001 -> result true, out_valid 1 edge after acceptance (top chunk decides).
- SLTU, x=0xFFFF, y=0x0001 -> result 0, out_valid after 1 chunk.
- SEQ, x=y=0x1234 -> result true after 4 chunk edges. SNE with the same operands -> 0, also after 4 chunk edges.
- SLT x=0x1230, y=0x1234 -> true after 4 edges. SLE x=y=0x8000 -> true. SLT x=0x8000, y=0x7FFF -> true after 1 edge.
- Hold out_ready=0 for 3 cycles in DONE:
  - result and out_valid stay stable and in_ready=0;
  - a second in_valid is ignored;
  - after the handshake, IDLE and the next request are accepted.
- Assert rst mid-RUN (idx=2) -> out_valid=0, in_ready=1, result=0 immediately without a clock edge; the next request completes normally.
- Build both with and without CMP_MASK_OUT_EN -> a true result is 0xFFFF vs 0x0001.
